sys_bus_guard: RTL and testbench
================================

// Module: sys_bus_guard
// PURPOSE
//  Pipeline-and-watchdog stage on the system bus. It sits between the PS AXI->sys bridge (master side)
//  and one housekeeping-class slave (slave side). Each request is registered once and held stable
//  toward the slave until the slave acks. A missing ack becomes an error response after TIMEOUT
//  cycles, so a dead or unmapped slave can never hang the CPU. Timeouts and stray acks are counted.
// PARAMETERS
//  AW       32            bus address width
//  DW       32            bus data width
//  TIMEOUT  64            cycles to wait for s_ack after issue; legal range 2..1023
//  ERR_DATA 32'hDEADBEEF  read data returned on timeout
//  CW       16            width of the status counters (saturating)
// PORTS
//  clk_i        in   1     system clock
//  rst_i        in   1     synchronous reset, active high
//  m_addr_i     in   AW    master address
//  m_wdata_i    in   DW    master write data
//  m_sel_i      in   4     master byte select
//  m_wen_i      in   1     master write strobe (1-cycle pulse)
//  m_ren_i      in   1     master read strobe (1-cycle pulse)
//  m_rdata_o    out  DW    read data to master
//  m_err_o      out  1     error to master
//  m_ack_o      out  1     ack to master (1-cycle pulse)
//  s_addr_o     out  AW    held address to slave
//  s_wdata_o    out  DW    held write data to slave
//  s_sel_o      out  4     held byte select to slave
//  s_wen_o      out  1     write strobe to slave (1-cycle pulse)
//  s_ren_o      out  1     read strobe to slave (1-cycle pulse)
//  s_rdata_i    in   DW    slave read data
//  s_err_i      in   1     slave error
//  s_ack_i      in   1     slave ack
//  clr_i        in   1     clears all status counters and flags
//  busy_o       out  1     transaction in flight (state != IDLE)
//  timeout_cnt_o out CW    number of timeouts, saturating
//  stray_cnt_o  out  CW    number of acks received in IDLE, saturating
//  drop_o       out  1     sticky: a strobe arrived while busy
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE. Any in-flight transaction is abandoned with no response.
//  IDLE: on m_wen_i|m_ren_i, latch addr/wdata/sel and drive s_wen_o/s_ren_o =1 for exactly the next
//   cycle, load wait counter=0, go WAIT. If wen and ren arrive together, issue a write only.
//  WAIT: the counter increments every cycle.
//   - s_ack_i=1: next cycle m_ack_o=1, m_err_o=s_err_i, m_rdata_o=s_rdata_i; return to IDLE.
//   - Counter reaches TIMEOUT-1 with no s_ack_i: next cycle m_ack_o=1, m_err_o=1, m_rdata_o=ERR_DATA,
//     timeout_cnt +1; return to IDLE.
//   - If s_ack_i arrives in the same cycle as the timeout, the ack wins and no timeout is counted.
//  Latency: master strobe at cycle 0 -> s_*en at 1. Slave ack at k -> m_ack_o at k+1.
//   A one-cycle slave gives m_ack_o at cycle 3.
//  m_ack_o/m_err_o are single-cycle pulses. m_rdata_o holds its last value between acks.
//  s_addr_o/s_wdata_o/s_sel_o hold their value until the next issue.
//  A strobe arriving in WAIT is not forwarded and gets no response; drop_o is set.
//   A strobe in the same cycle as the completing ack is also dropped.
//  An s_ack_i arriving in IDLE (late ack after a timeout) is ignored toward the master;
//   stray_cnt is incremented.
//  Counters saturate at all-ones. clr_i zeroes both counters and drop_o.
//   clr_i coincident with an increment: clear wins. clr_i does not disturb the FSM.
// STRUCTURE
//  Package sys_bus_pkg: state enum {IDLE, WAIT}, ERR_DATA default, bus width constants.
//  Sub-module sat_cnt #(CW) (inc, clr -> cnt, saturating, clr priority), instantiated twice.
//  The wait counter is a local clog2(TIMEOUT)-bit register.
// TESTING
//  1 Write addr 0x30 data 0xA5 to a 1-cycle slave -> s_wen_o @1 with held 0x30/0xA5;
//    m_ack_o @3, m_err_o=0.
//  2 Read with slave returning 0x12345678 after 5 cycles -> m_rdata_o=0x12345678,
//    m_ack_o exactly 1 cycle after s_ack_i.
//  3 Read to silent slave, TIMEOUT=64 -> m_ack_o=1, m_err_o=1, m_rdata_o=0xDEADBEEF
//    at cycle 65 after issue; timeout_cnt_o=1.
//  4 Silent slave, then s_ack_i 10 cycles after the timeout -> no m_ack_o; stray_cnt_o=1.
//    s_ack_i exactly on the timeout cycle -> normal ack, timeout_cnt_o unchanged.
//  5 Second strobe while in WAIT -> not forwarded, drop_o=1. clr_i -> drop_o=0 and counters=0,
//    including clr_i coincident with a timeout.
//  6 Assert rst_i mid-WAIT, then s_ack_i -> all outputs 0, no m_ack_o, state IDLE;
//    the next request completes normally.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared constants, state type and helpers for the system-bus guard stage.
package sys_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Wait-counter width; never below one bit so a TIMEOUT of 2 still has a register.
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/sys_bus_guard_if.sv
// System-bus request/response bundle; master drives the request, slave answers.
interface sys_bus_if
  import sys_bus_pkg::*;
#(
  parameter int unsigned AW = BUS_AW,
  parameter int unsigned DW = BUS_DW
);

  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [BUS_SW-1:0] sel;
  logic              wen;
  logic              ren;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              ack;

  modport master (
    output addr, wdata, sel, wen, ren,
    input  rdata, err, ack
  );

  modport slave (
    input  addr, wdata, sel, wen, ren,
    output rdata, err, ack
  );

endinterface

// File: rtl/sys_bus_guard_sat_cnt.sv
// Saturating status counter with clear taking priority over increment.
module sat_cnt #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sys_bus_guard.sv
// Registers one request toward the slave, holds it until ack, and converts a
// missing ack into an error response after TIMEOUT cycles.
module sys_bus_guard
  import sys_bus_pkg::*;
#(
  parameter int unsigned    AW       = BUS_AW,
  parameter int unsigned    DW       = BUS_DW,
  parameter int unsigned    TIMEOUT  = 64,
  parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEFAULT),
  parameter int unsigned    CW       = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sys_bus_if.slave      m_bus,
  sys_bus_if.master     s_bus,
  input  logic          clr_i,
  output logic          busy_o,
  output logic [CW-1:0] timeout_cnt_o,
  output logic [CW-1:0] stray_cnt_o,
  output logic          drop_o
);

  localparam int unsigned     WCW       = wait_cnt_width(TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WCW-1:0]    wait_q, wait_d;

  logic              strobe;
  logic              issue;
  logic              done_ack;
  logic              done_to;
  logic              stray_inc;
  logic              drop_set;

  logic [AW-1:0]     s_addr_q;
  logic [DW-1:0]     s_wdata_q;
  logic [BUS_SW-1:0] s_sel_q;
  logic              s_wen_q;
  logic              s_ren_q;
  logic [DW-1:0]     m_rdata_q;
  logic              m_err_q;
  logic              m_ack_q;
  logic              drop_q;

  assign strobe = m_bus.wen | m_bus.ren;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    issue    = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          issue   = 1'b1;
          wait_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q + WCW'(1);
        // Ack is checked first so an ack on the last wait cycle beats the timeout.
        if (s_bus.ack) begin
          done_ack = 1'b1;
          state_d  = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          done_to = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stray_inc = (state_q == IDLE) && s_bus.ack;
  assign drop_set  = (state_q == WAIT) && strobe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
      s_wen_q   <= 1'b0;
      s_ren_q   <= 1'b0;
      m_rdata_q <= '0;
      m_err_q   <= 1'b0;
      m_ack_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      s_wen_q <= issue && m_bus.wen;
      s_ren_q <= issue && m_bus.ren && !m_bus.wen;
      if (issue) begin
        s_addr_q  <= m_bus.addr;
        s_wdata_q <= m_bus.wdata;
        s_sel_q   <= m_bus.sel;
      end

      m_ack_q <= done_ack || done_to;
      m_err_q <= done_ack ? s_bus.err : done_to;
      if (done_ack) begin
        m_rdata_q <= s_bus.rdata;
      end else if (done_to) begin
        m_rdata_q <= ERR_DATA;
      end

      if (clr_i) begin
        drop_q <= 1'b0;
      end else if (drop_set) begin
        drop_q <= 1'b1;
      end
    end
  end

  sat_cnt #(.CW(CW)) u_timeout_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (done_to),
    .clr_i (clr_i),
    .cnt_o (timeout_cnt_o)
  );

  sat_cnt #(.CW(CW)) u_stray_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stray_inc),
    .clr_i (clr_i),
    .cnt_o (stray_cnt_o)
  );

  assign s_bus.addr  = s_addr_q;
  assign s_bus.wdata = s_wdata_q;
  assign s_bus.sel   = s_sel_q;
  assign s_bus.wen   = s_wen_q;
  assign s_bus.ren   = s_ren_q;

  assign m_bus.rdata = m_rdata_q;
  assign m_bus.err   = m_err_q;
  assign m_bus.ack   = m_ack_q;

  assign busy_o = (state_q != IDLE);
  assign drop_o = drop_q;

endmodule

// File: tb/tb_sys_bus_guard.sv
// Directed bench for sys_bus_guard: a cycle-stamped transaction model checked every cycle,
// plus literal checkpoints taken from the expected latencies.
module tb_sys_bus_guard;

  localparam int unsigned TO   = 64;
  localparam int unsigned CW   = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          busy;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] scnt;
  logic          drop;

  int n_cmp = 0;
  int n_bad = 0;

  sys_bus_if #(.AW(32), .DW(32)) m_bus ();
  sys_bus_if #(.AW(32), .DW(32)) s_bus ();

  sys_bus_guard #(.TIMEOUT(TO), .CW(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_bus         (m_bus),
    .s_bus         (s_bus),
    .clr_i         (clr),
    .busy_o        (busy),
    .timeout_cnt_o (tcnt),
    .stray_cnt_o   (scnt),
    .drop_o        (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request issued at cycle t0 may be answered by an ack in
  // cycles t0+1 .. t0+TO; otherwise an error response appears at t0+TO+1.
  int unsigned cyc = 0;
  int unsigned t0  = 0;
  bit          mbusy  = 1'b0;
  bit          mvalid = 1'b0;
  logic        e_ack, e_err, e_swen, e_sren, e_drop;
  logic [31:0] e_rdata, e_saddr, e_swdata;
  logic [3:0]  e_ssel;
  int unsigned e_to, e_stray;

  always @(posedge clk) begin
    if (rst) begin
      mbusy = 1'b0; mvalid = 1'b1;
      e_ack = 1'b0; e_err = 1'b0; e_swen = 1'b0; e_sren = 1'b0; e_drop = 1'b0;
      e_rdata = '0; e_saddr = '0; e_swdata = '0; e_ssel = '0;
      e_to = 0; e_stray = 0;
    end else begin
      e_ack = 1'b0; e_err = 1'b0; e_swen = 1'b0; e_sren = 1'b0;
      if (mbusy) begin
        if (m_bus.wen || m_bus.ren) e_drop = 1'b1;
        if (s_bus.ack) begin
          e_ack = 1'b1; e_err = s_bus.err; e_rdata = s_bus.rdata; mbusy = 1'b0;
        end else if (cyc - t0 == TO) begin
          e_ack = 1'b1; e_err = 1'b1; e_rdata = 32'hDEAD_BEEF; mbusy = 1'b0;
          if (e_to < CMAX) e_to++;
        end
      end else begin
        if (s_bus.ack && e_stray < CMAX) e_stray++;
        if (m_bus.wen || m_bus.ren) begin
          t0 = cyc; mbusy = 1'b1;
          e_saddr = m_bus.addr; e_swdata = m_bus.wdata; e_ssel = m_bus.sel;
          e_swen = m_bus.wen; e_sren = !m_bus.wen;
        end
      end
      if (clr) begin
        e_to = 0; e_stray = 0; e_drop = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("m_ack",   32'(m_bus.ack),   32'(e_ack));
      check("m_err",   32'(m_bus.err),   32'(e_err));
      check("m_rdata", m_bus.rdata,      e_rdata);
      check("s_wen",   32'(s_bus.wen),   32'(e_swen));
      check("s_ren",   32'(s_bus.ren),   32'(e_sren));
      check("s_addr",  s_bus.addr,       e_saddr);
      check("s_wdata", s_bus.wdata,      e_swdata);
      check("s_sel",   32'(s_bus.sel),   32'(e_ssel));
      check("busy",    32'(busy),        32'(mbusy));
      check("tcnt",    32'(tcnt),        e_to);
      check("scnt",    32'(scnt),        e_stray);
      check("drop",    32'(drop),        32'(e_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    m_bus.addr = '0; m_bus.wdata = '0; m_bus.sel = '0; m_bus.wen = 1'b0; m_bus.ren = 1'b0;
    s_bus.rdata = '0; s_bus.err = 1'b0; s_bus.ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ack",  32'(m_bus.ack), 32'd0);
    check("rst_busy", 32'(busy),      32'd0);
    check("rst_tcnt", 32'(tcnt),      32'd0);

    // 1: write to a one-cycle slave
    m_bus.addr = 32'h30; m_bus.wdata = 32'hA5; m_bus.sel = 4'hF; m_bus.wen = 1'b1;
    tick();                                       // cycle 1
    m_bus.wen = 1'b0;
    check("t1_swen",  32'(s_bus.wen), 32'd1);
    check("t1_saddr", s_bus.addr,     32'h30);
    check("t1_swdat", s_bus.wdata,    32'hA5);
    tick();                                       // cycle 2
    check("t1_noack", 32'(m_bus.ack), 32'd0);
    s_bus.ack = 1'b1;
    tick();                                       // cycle 3
    s_bus.ack = 1'b0;
    check("t1_ack",   32'(m_bus.ack), 32'd1);
    check("t1_err",   32'(m_bus.err), 32'd0);

    // 2: read, slave answers at cycle 5
    m_bus.addr = 32'h44; m_bus.ren = 1'b1;
    tick();                                       // cycle 1
    m_bus.ren = 1'b0;
    check("t2_sren",  32'(s_bus.ren), 32'd1);
    check("t2_swen",  32'(s_bus.wen), 32'd0);
    repeat (4) tick();                            // cycle 5
    check("t2_pre",   32'(m_bus.ack), 32'd0);
    s_bus.ack = 1'b1; s_bus.rdata = 32'h1234_5678;
    tick();                                       // cycle 6
    s_bus.ack = 1'b0; s_bus.rdata = '0;
    check("t2_ack",   32'(m_bus.ack), 32'd1);
    check("t2_rdata", m_bus.rdata,    32'h1234_5678);
    tick();
    check("t2_pulse", 32'(m_bus.ack), 32'd0);
    check("t2_hold",  m_bus.rdata,    32'h1234_5678);

    // 3: read to a silent slave
    m_bus.addr = 32'h80; m_bus.ren = 1'b1;
    tick();                                       // cycle 1
    m_bus.ren = 1'b0;
    repeat (63) tick();                           // cycle 64
    check("t3_pre",   32'(m_bus.ack), 32'd0);
    tick();                                       // cycle 65
    check("t3_ack",   32'(m_bus.ack), 32'd1);
    check("t3_err",   32'(m_bus.err), 32'd1);
    check("t3_rdata", m_bus.rdata,    32'hDEAD_BEEF);
    check("t3_tcnt",  32'(tcnt),      32'd1);

    // 4a: late ack ten cycles after the timeout
    repeat (10) tick();
    s_bus.ack = 1'b1;
    tick();
    s_bus.ack = 1'b0;
    check("t4_noack", 32'(m_bus.ack), 32'd0);
    check("t4_stray", 32'(scnt),      32'd1);

    // 4b: ack exactly on the timeout cycle wins
    m_bus.addr = 32'h84; m_bus.ren = 1'b1;
    tick();                                       // cycle 1
    m_bus.ren = 1'b0;
    repeat (63) tick();                           // cycle 64
    s_bus.ack = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
    tick();                                       // cycle 65
    s_bus.ack = 1'b0; s_bus.rdata = '0;
    check("t4_ack",   32'(m_bus.ack), 32'd1);
    check("t4_err",   32'(m_bus.err), 32'd0);
    check("t4_rdata", m_bus.rdata,    32'hCAFE_F00D);
    check("t4_tcnt",  32'(tcnt),      32'd1);

    // 5: strobe while busy is dropped; clr clears flags and counters
    m_bus.addr = 32'h90; m_bus.wdata = 32'h5A; m_bus.wen = 1'b1;
    tick();                                       // cycle 1
    m_bus.wen = 1'b0; m_bus.ren = 1'b1; m_bus.addr = 32'h94;
    tick();                                       // cycle 2
    m_bus.ren = 1'b0;
    check("t5_nofwd", 32'(s_bus.ren), 32'd0);
    check("t5_held",  s_bus.addr,     32'h90);
    check("t5_drop",  32'(drop),      32'd1);
    clr = 1'b1;
    tick();                                       // cycle 3
    clr = 1'b0;
    check("t5_cdrop", 32'(drop),      32'd0);
    check("t5_ctcnt", 32'(tcnt),      32'd0);
    check("t5_cscnt", 32'(scnt),      32'd0);
    s_bus.ack = 1'b1; m_bus.wen = 1'b1; m_bus.addr = 32'h98;
    tick();                                       // cycle 4
    s_bus.ack = 1'b0; m_bus.wen = 1'b0;
    check("t5_ack",   32'(m_bus.ack), 32'd1);
    check("t5_cowen", 32'(s_bus.wen), 32'd0);
    check("t5_codrp", 32'(drop),      32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_bus.addr = 32'hA0; m_bus.ren = 1'b1;
    tick();                                       // cycle 1
    m_bus.ren = 1'b0;
    repeat (63) tick();                           // cycle 64
    clr = 1'b1;
    tick();                                       // cycle 65
    clr = 1'b0;
    check("t5_toack", 32'(m_bus.ack), 32'd1);
    check("t5_toerr", 32'(m_bus.err), 32'd1);
    check("t5_clrwn", 32'(tcnt),      32'd0);

    // stray counter saturates at all-ones
    s_bus.ack = 1'b1;
    repeat (9) tick();
    s_bus.ack = 1'b0;
    check("sat_scnt", 32'(scnt), CMAX);

    // 6: reset mid-WAIT, ack during reset, then a normal request
    m_bus.addr = 32'hB0; m_bus.ren = 1'b1;
    tick();                                       // cycle 1
    m_bus.ren = 1'b0;
    repeat (4) tick();
    check("t6_busy",  32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    s_bus.ack = 1'b1;
    tick();
    rst = 1'b0; s_bus.ack = 1'b0;
    tick();
    check("t6_ack",   32'(m_bus.ack), 32'd0);
    check("t6_busy0", 32'(busy),      32'd0);
    check("t6_rdata", m_bus.rdata,    32'd0);
    check("t6_saddr", s_bus.addr,     32'd0);
    check("t6_scnt",  32'(scnt),      32'd0);
    m_bus.addr = 32'hC4; m_bus.wdata = 32'h77; m_bus.sel = 4'h3; m_bus.wen = 1'b1;
    tick();                                       // cycle 1
    m_bus.wen = 1'b0;
    check("t6_swen",  32'(s_bus.wen), 32'd1);
    check("t6_ssel",  32'(s_bus.sel), 32'h3);
    tick();                                       // cycle 2
    s_bus.ack = 1'b1;
    tick();                                       // cycle 3
    s_bus.ack = 1'b0;
    check("t6_ack3",  32'(m_bus.ack), 32'd1);
    check("t6_err3",  32'(m_bus.err), 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
